task_out_packetizer: RTL
========================

// Module: task_out_packetizer
// PURPOSE
//  Buffers result words from a task core into one packet and streams it to the task manager as bytes.
//  The packet length is variable, 1..NUM_WORDS words. The packet closes on i_input_last or when the buffer is full.
//  Announces the byte count, then serialises each word into WRITE_DATA_WIDTH/8 bytes with valid/ready handshaking.
//  Successor to the fixed-length task output stage: width-generic, variable-length, backpressure-aware.
// PARAMETERS
//  WRITE_DATA_WIDTH  8   input word width; must be a multiple of 8
//  READ_DATA_WIDTH   8   output byte width; fixed at 8, elaboration error otherwise
//  NUM_WORDS         81  max words per packet; NUM_WORDS*WRITE_DATA_WIDTH/8 + 1 <= 4095 (checked at elaboration)
// PORTS
//  i_clk                   in   1     clock
//  i_rst                   in   1     asynchronous active-high reset
//  i_data                  in   WDW   input word
//  i_data_valid            in   1     input beat valid
//  i_input_last            in   1     qualifies final input beat of packet
//  o_in_ready              out  1     buffer accepts input beat
//  i_tmanager_ready        in   1     manager accepts output byte
//  o_tanswer_ready         out  1     output byte valid (held until accepted)
//  o_tdata                 out  8     output byte
//  o_tanswer_data_last     out  1     final byte of packet, coincident with o_tanswer_ready
//  o_packet_size_in_bytes  out  12    byte count; valid from ANNOUNCE until last byte accepted, else 0
//  o_busy                  out  1     high in ANNOUNCE and SEND
//  o_full                  out  1     buffer holds NUM_WORDS words
// BEHAVIOUR
//  Reset: all outputs 0 except o_in_ready=1; state IDLE; word count and read pointers cleared; buffer contents discarded.
//  Reset is asynchronous. Assertion mid-LOAD or mid-SEND aborts the packet immediately; no last byte is emitted.
//  Input accept: i_data_valid && o_in_ready. o_in_ready = (state==IDLE || state==LOAD) && count<NUM_WORDS.
//  FSM:
//   IDLE     -> LOAD on an accepted beat (the beat is stored). Same-cycle beat with i_input_last goes straight to ANNOUNCE.
//   LOAD     -> ANNOUNCE on an accepted beat with i_input_last, or when count reaches NUM_WORDS (o_full=1, o_in_ready=0).
//   ANNOUNCE -> SEND, one cycle. o_packet_size_in_bytes <= count*WDW/8 (+1 with checksum); o_busy=1; o_tanswer_ready=0.
//   SEND     -> IDLE on the last byte accepted (ready&&valid&&last). Count, pointers and size are cleared there.
//  Handshake and latency:
//   o_tanswer_ready=1 throughout SEND. A byte advances only on i_tmanager_ready. o_tdata is stable while stalled.
//   Serialisation is little-endian: byte lane 0 (bits[7:0]) of word 0 first, then lane 1, and so on.
//   The lane counter wraps to 0 and the word pointer increments after lane WDW/8-1.
//   First byte is valid the cycle after ANNOUNCE. Throughput is 1 byte/cycle with ready held high.
//  Boundaries:
//   A single-word packet is legal.
//   i_input_last on the NUM_WORDS-th beat closes the packet once; no double transition.
//   i_data_valid in ANNOUNCE/SEND is ignored (o_in_ready=0) and no data is lost from the buffer.
//   o_full deasserts on the transition to IDLE.
// CONFIGURATION
//  Macro TASK_OUT_CHECKSUM_EN:
//   Defined: a running XOR of all data bytes is appended as one extra byte after the final data byte.
//    o_tanswer_data_last marks the checksum byte; packet size includes it (+1).
//    The XOR register clears on IDLE entry and on reset.
//   Undefined: no checksum logic. The last data byte carries o_tanswer_data_last.
// STRUCTURE
//  Shared package task_out_pkg:
//   typedef enum logic [1:0] {s_IDLE, s_LOAD, s_ANNOUNCE, s_SEND} task_out_state_t;
//   localparam BYTE_W = 8; localparam PKT_SIZE_W = 12.
//  One sub-module, task_out_serializer: selects byte lane from the current word, owns the lane/word counters
//  and the last-byte flag, and advances on ready&&valid.
//  Buffer storage is a register array NUM_WORDS x WDW with combinational read.
// TESTING
//  T1 WDW=8, NUM_WORDS=81, 81 beats 0..80, ready=1:
//     o_full after beat 81; size=81; bytes 0..80; last on byte 80; returns to IDLE.
//  T2 WDW=32, 3 words with last on 3rd (0x44332211, 0x88776655, 0xCCBBAA99):
//     size=12; bytes 11,22,..,CC; last on 0xCC.
//  T3 T2 stimulus, ready toggling 1-0-0-1:
//     o_tdata and last stable during stalls; no byte dropped or duplicated.
//  T4 single beat 0x5A with last in IDLE:
//     ANNOUNCE next cycle, size=1; single byte 0x5A with last. Checksum build: size=2, bytes 5A,5A with last on 2nd.
//  T5 i_rst pulse mid-SEND after 10 bytes:
//     all outputs reset asynchronously. A new 2-word packet then streams correctly from word 0.
//  T6 i_data_valid held high during ANNOUNCE/SEND:
//     o_in_ready=0, no extra words stored; next packet contains only post-IDLE beats.

Source files
------------

// File: rtl/task_out_packetizer_pkg.sv
// Shared types and constants for the task output packetizer.
package task_out_pkg;

  localparam int BYTE_W     = 8;
  localparam int PKT_SIZE_W = 12;

  typedef enum logic [1:0] {s_IDLE, s_LOAD, s_ANNOUNCE, s_SEND} task_out_state_t;

  // Index width that stays at least one bit for single-entry ranges.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/task_out_packetizer_if.sv
// Word-in / byte-out handshake bundle between task core, packetizer and task manager.
interface task_out_packetizer_if import task_out_pkg::*; #(
  parameter int WRITE_DATA_WIDTH = 8
);
  logic [WRITE_DATA_WIDTH-1:0] data;
  logic                        data_valid;
  logic                        input_last;
  logic                        in_ready;
  logic                        tmanager_ready;
  logic                        tanswer_ready;
  logic [BYTE_W-1:0]           tdata;
  logic                        tanswer_data_last;
  logic [PKT_SIZE_W-1:0]       packet_size_in_bytes;
  logic                        busy;
  logic                        full;

  modport master (
    output data, data_valid, input_last, tmanager_ready,
    input  in_ready, tanswer_ready, tdata, tanswer_data_last,
           packet_size_in_bytes, busy, full
  );

  modport slave (
    input  data, data_valid, input_last, tmanager_ready,
    output in_ready, tanswer_ready, tdata, tanswer_data_last,
           packet_size_in_bytes, busy, full
  );
endinterface

// File: rtl/task_out_packetizer_serializer.sv
// Splits buffered words into little-endian bytes; owns lane/word counters and the last-byte flag.
// Optional trailing XOR checksum byte under `TASK_OUT_CHECKSUM_EN.
module task_out_serializer import task_out_pkg::*; #(
  parameter int WRITE_DATA_WIDTH = 8,
  parameter int NUM_WORDS        = 81
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                active,
  input  logic                                ready,
  input  logic [cnt_width(NUM_WORDS)-1:0]     count,
  input  logic [WRITE_DATA_WIDTH-1:0]         word,
  output logic [ptr_width(NUM_WORDS)-1:0]     word_ptr,
  output logic [BYTE_W-1:0]                   tdata,
  output logic                                last,
  output logic                                done
);
  localparam int BPW    = WRITE_DATA_WIDTH / BYTE_W;
  localparam int LANE_W = ptr_width(BPW);
  localparam int CNT_W  = cnt_width(NUM_WORDS);
  localparam int PTR_W  = ptr_width(NUM_WORDS);

  logic [LANE_W-1:0] lane;
  logic [BYTE_W-1:0] lane_byte;
  logic              last_data;
  logic              advance;
  logic              step_en;

  always_comb begin
    lane_byte = '0;
    for (int unsigned i = 0; i < BPW; i++)
      if (lane == LANE_W'(i)) lane_byte = word[i*BYTE_W +: BYTE_W];
  end

  assign last_data = (CNT_W'(word_ptr) == count - CNT_W'(1)) && (lane == LANE_W'(BPW - 1));
  assign advance   = active && ready;
  assign done      = advance && last;

`ifdef TASK_OUT_CHECKSUM_EN
  logic [BYTE_W-1:0] csum;
  logic              csum_phase;

  // Pointers park on the final data byte so the buffer read stays in range during the checksum byte.
  assign step_en = advance && !csum_phase && !last_data;
  assign tdata   = !active ? '0 : (csum_phase ? csum : lane_byte);
  assign last    = active && csum_phase;
`else
  assign step_en = advance && !last_data;
  assign tdata   = active ? lane_byte : '0;
  assign last    = active && last_data;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane     <= '0;
      word_ptr <= '0;
`ifdef TASK_OUT_CHECKSUM_EN
      csum       <= '0;
      csum_phase <= 1'b0;
`endif
    end else if (done) begin
      lane     <= '0;
      word_ptr <= '0;
`ifdef TASK_OUT_CHECKSUM_EN
      csum       <= '0;
      csum_phase <= 1'b0;
`endif
    end else begin
      if (step_en) begin
        if (lane == LANE_W'(BPW - 1)) begin
          lane     <= '0;
          word_ptr <= word_ptr + PTR_W'(1);
        end else begin
          lane <= lane + LANE_W'(1);
        end
      end
`ifdef TASK_OUT_CHECKSUM_EN
      if (advance && !csum_phase) begin
        csum       <= csum ^ lane_byte;
        csum_phase <= last_data;
      end
`endif
    end
  end

endmodule

// File: rtl/task_out_packetizer.sv
// Buffers 1..NUM_WORDS result words into a packet, announces its byte count, then streams bytes.
// `TASK_OUT_CHECKSUM_EN appends an XOR checksum byte and counts it in the packet size.
module task_out_packetizer import task_out_pkg::*; #(
  parameter int WRITE_DATA_WIDTH = 8,
  parameter int READ_DATA_WIDTH  = 8,
  parameter int NUM_WORDS        = 81
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  task_out_packetizer_if.slave bus
);
  localparam int BPW   = WRITE_DATA_WIDTH / BYTE_W;
  localparam int CNT_W = cnt_width(NUM_WORDS);
  localparam int PTR_W = ptr_width(NUM_WORDS);
`ifdef TASK_OUT_CHECKSUM_EN
  localparam int CSUM_BYTES = 1;
`else
  localparam int CSUM_BYTES = 0;
`endif

  if (READ_DATA_WIDTH != BYTE_W) begin : g_bad_read_width
    $error("READ_DATA_WIDTH must be 8");
  end
  if (WRITE_DATA_WIDTH % BYTE_W != 0 || WRITE_DATA_WIDTH < BYTE_W) begin : g_bad_write_width
    $error("WRITE_DATA_WIDTH must be a nonzero multiple of 8");
  end
  if (NUM_WORDS < 1 || NUM_WORDS * BPW + 1 > 4095) begin : g_bad_depth
    $error("NUM_WORDS*WRITE_DATA_WIDTH/8 + 1 must not exceed 4095");
  end

  task_out_state_t             state;
  logic [CNT_W-1:0]            count;
  logic [CNT_W-1:0]            cnt_next;
  logic [WRITE_DATA_WIDTH-1:0] mem [NUM_WORDS];
  logic [PTR_W-1:0]            word_ptr;
  logic                        accept;
  logic                        active;
  logic                        done;

  assign bus.in_ready = (state == s_IDLE || state == s_LOAD) && (count < CNT_W'(NUM_WORDS));
  assign accept       = bus.data_valid && bus.in_ready;
  assign cnt_next     = count + CNT_W'(1);
  assign active       = (state == s_SEND);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= s_IDLE;
      count <= '0;
    end else begin
      case (state)
        s_IDLE, s_LOAD:
          if (accept) begin
            count <= cnt_next;
            state <= (bus.input_last || cnt_next == CNT_W'(NUM_WORDS)) ? s_ANNOUNCE : s_LOAD;
          end
        s_ANNOUNCE: state <= s_SEND;
        s_SEND:
          if (done) begin
            state <= s_IDLE;
            count <= '0;
          end
        default: state <= s_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (accept) mem[count[PTR_W-1:0]] <= bus.data;
  end

  assign bus.busy                 = (state == s_ANNOUNCE) || active;
  assign bus.full                 = (count == CNT_W'(NUM_WORDS));
  assign bus.tanswer_ready        = active;
  assign bus.packet_size_in_bytes = bus.busy
      ? PKT_SIZE_W'(count) * PKT_SIZE_W'(BPW) + PKT_SIZE_W'(CSUM_BYTES)
      : '0;

  task_out_serializer #(
    .WRITE_DATA_WIDTH (WRITE_DATA_WIDTH),
    .NUM_WORDS        (NUM_WORDS)
  ) u_serializer (
    .clk      (i_clk),
    .rst      (i_rst),
    .active   (active),
    .ready    (bus.tmanager_ready),
    .count    (count),
    .word     (mem[word_ptr]),
    .word_ptr (word_ptr),
    .tdata    (bus.tdata),
    .last     (bus.tanswer_data_last),
    .done     (done)
  );

endmodule
